// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit: one bit per cycle, results land in HI/LO.
// Multiply is shift-add and divide is restoring, both on operand magnitudes, with sign fix-up.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             stall_o,
    output logic             done_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e            state, state_next;
    logic [CntW-1:0]   count;
    logic              is_div, div_zero, neg_main, neg_rem;
    logic [WIDTH-1:0]  acc_hi, acc_lo, operand, dividend_raw;
    logic [WIDTH-1:0]  hi, lo;
    logic              done;

    logic              accept;
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    mul_sum, div_rem, div_diff;
    logic [WIDTH-1:0]  step_hi, step_lo;
    logic [2*WIDTH-1:0] product, product_fix;
    logic [WIDTH-1:0]  fix_hi, fix_lo;

    assign accept  = (state == StIdle) && start_i && !flush_i;
    assign stall_o = accept || (state == StRun);
    assign hi_o    = hi;
    assign lo_o    = lo;
    assign done_o  = done;

    always_comb begin
        a_neg = op_i[0] & src_a_i[WIDTH-1];
        b_neg = op_i[0] & src_b_i[WIDTH-1];
        a_mag = a_neg ? (~src_a_i + WIDTH'(1)) : src_a_i;
        b_mag = b_neg ? (~src_b_i + WIDTH'(1)) : src_b_i;
    end

    // acc_hi is the product upper half / partial remainder; acc_lo the multiplier / quotient.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        div_rem  = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_rem - {1'b0, operand};
        step_hi  = '0;
        step_lo  = '0;
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_rem[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        product     = {acc_hi, acc_lo};
        product_fix = neg_main ? (~product + (2*WIDTH)'(1)) : product;
        fix_hi      = product_fix[2*WIDTH-1:WIDTH];
        fix_lo      = product_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = dividend_raw;
                fix_lo = '1;
            end else begin
                fix_hi = neg_rem  ? (~acc_hi + WIDTH'(1)) : acc_hi;
                fix_lo = neg_main ? (~acc_lo + WIDTH'(1)) : acc_lo;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            StIdle: if (accept) state_next = StRun;
            StRun: begin
                if (flush_i) begin
                    state_next = StIdle;
                end else if (count == LastCnt) begin
                    state_next = StFix;
                end
            end
            StFix:   state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            count        <= '0;
            is_div       <= 1'b0;
            div_zero     <= 1'b0;
            neg_main     <= 1'b0;
            neg_rem      <= 1'b0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            operand      <= '0;
            dividend_raw <= '0;
            hi           <= '0;
            lo           <= '0;
            done         <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == StFix) && !flush_i;
            if (accept) begin
                count        <= '0;
                is_div       <= op_i[1];
                div_zero     <= (src_b_i == '0);
                neg_main     <= a_neg ^ b_neg;
                neg_rem      <= a_neg;
                dividend_raw <= src_a_i;
                acc_hi       <= '0;
                acc_lo       <= op_i[1] ? a_mag : b_mag;
                operand      <= op_i[1] ? b_mag : a_mag;
            end else if (state == StRun) begin
                count  <= count + CntW'(1);
                acc_hi <= step_hi;
                acc_lo <= step_lo;
            end
            if ((state == StFix) && !flush_i) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule
